// File: rtl/hdmi_timing_pkg.sv
// Shared constants for the HDMI raster sequencer: default 640x480@60 timing
// and the update-window FSM state encoding.
package hdmi_timing_pkg;

    localparam int DEF_CLK_DIV  = 10;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam logic DEF_SYNC_POL = 1'b0;
    localparam int DEF_PIX_LAT  = 2;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        UPD_IDLE  = 2'd0,
        UPD_GRANT = 2'd1,
        UPD_DONE  = 2'd2
    } upd_state_t;

endpackage

// File: rtl/hdmi_timing_ctrl_pix_ce_gen.sv
// Pixel clock-enable divider: free-running 0..CLK_DIV-1 counter on clk_fast.
// pix_ce_pre fires one cycle ahead so downstream registers can line up with pix_ce.
module pix_ce_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk_fast,
    input  logic rst_n,
    output logic pix_ce,
    output logic pix_ce_pre
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign pix_ce     = (cnt == CNT_LAST);
    assign pix_ce_pre = (cnt == CNT_PRE);

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// HDMI/TMDS timing sequencer: raster counters, early pixel-fetch requests,
// registered VDE/sync control data and the vblank update-window handshake.
module hdmi_timing_ctrl
    import hdmi_timing_pkg::*;
#(
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL,
    parameter int   PIX_LAT  = DEF_PIX_LAT
) (
    input  logic               clk_fast,
    input  logic               rst_n,
    output logic               pix_ce,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic               px_req,
    output logic               VDE,
    output logic [1:0]         CD,
    output logic               frame_start,
    input  logic               upd_req,
    output logic               upd_grant,
    output logic               upd_overrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS      = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] H_SYNC_BEG = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SYNC_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_VIS      = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] V_SYNC_BEG = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SYNC_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] ONE        = COORD_W'(1);
    localparam logic [COORD_W:0]   H_TOTAL_W  = (COORD_W + 1)'(H_TOTAL);
    localparam logic [COORD_W:0]   LAT_W      = (COORD_W + 1)'(PIX_LAT);

    logic               pix_ce_pre;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic [COORD_W:0]   lead_h_sum;
    logic [COORD_W-1:0] lead_h;
    logic [COORD_W-1:0] lead_v;
    logic               lead_vis;
    logic               hsync_lvl;
    logic               vsync_lvl;
    upd_state_t         state;
    upd_state_t         state_next;
    logic               revoke;

    pix_ce_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_ce_gen (
        .clk_fast  (clk_fast),
        .rst_n     (rst_n),
        .pix_ce    (pix_ce),
        .pix_ce_pre(pix_ce_pre)
    );

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
            end else begin
                h_cnt <= h_cnt + ONE;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        lead_h_sum = {1'b0, h_cnt} + LAT_W;
        lead_h     = lead_h_sum[COORD_W-1:0];
        lead_v     = v_cnt;
        if (lead_h_sum >= H_TOTAL_W) begin
            lead_h = COORD_W'(lead_h_sum - H_TOTAL_W);
            lead_v = (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
        end
    end

    assign lead_vis  = (lead_h < H_VIS) && (lead_v < V_VIS);
    assign hsync_lvl = (h_cnt >= H_SYNC_BEG && h_cnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    assign vsync_lvl = (v_cnt >= V_SYNC_BEG && v_cnt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;

    // Raster holds still between strobes, so sampling on pix_ce_pre presents
    // the request and frame marker exactly in the pix_ce cycle.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            px_req      <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            frame_start <= 1'b0;
        end else begin
            px_req      <= pix_ce_pre && lead_vis;
            frame_start <= pix_ce_pre && (h_cnt == '0) && (v_cnt == '0);
            if (pix_ce_pre && lead_vis) begin
                px_x <= lead_h;
                px_y <= lead_v;
            end
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            VDE <= 1'b0;
            CD  <= {~SYNC_POL, ~SYNC_POL};
        end else if (pix_ce) begin
            VDE <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
            CD  <= {vsync_lvl, hsync_lvl};
        end
    end

    // Revocation at the last line wins over a simultaneous request drop.
    always_comb begin
        state_next = state;
        revoke     = 1'b0;
        case (state)
            UPD_IDLE: begin
                if (upd_req && v_cnt >= V_VIS && v_cnt < V_LAST) begin
                    state_next = UPD_GRANT;
                end
            end
            UPD_GRANT: begin
                if (v_cnt == V_LAST) begin
                    state_next = UPD_DONE;
                    revoke     = 1'b1;
                end else if (!upd_req) begin
                    state_next = UPD_IDLE;
                end
            end
            UPD_DONE: begin
                if (v_cnt == '0) begin
                    state_next = UPD_IDLE;
                end
            end
            default: state_next = UPD_IDLE;
        endcase
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state       <= UPD_IDLE;
            upd_grant   <= 1'b0;
            upd_overrun <= 1'b0;
        end else begin
            state     <= state_next;
            upd_grant <= (state_next == UPD_GRANT);
            if (revoke) begin
                upd_overrun <= 1'b1;
            end
        end
    end

endmodule
